// File: rtl/vga_pixel_fetch_ctrl.sv
// vga_pixel_fetch_ctrl: sequences pixel ROM reads into a prefetch FIFO and serves one word per pixel request
module vga_pixel_fetch_ctrl #(
  parameter int DATA_W = 8,
  parameter int H_PIX = 160,
  parameter int V_LINES = 120,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_W = $clog2(H_PIX*V_LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start_in,
  input  logic              pix_req_in,
  output logic              rom_rd_en_out,
  output logic [ADDR_W-1:0] rom_addr_out,
  input  logic [DATA_W-1:0] rom_dat_in,
  output logic [DATA_W-1:0] pix_dat_out,
  output logic              pix_vld_out,
  output logic              ready_out,
  output logic              underrun_out
);
  localparam int LAST = H_PIX*V_LINES-1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW+1;
  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, DONE} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [CW:0] pending;
  logic [ADDR_W-1:0] addr;
  logic rd_en_d, drop, last_done;
  logic push, pop_req, pop, bypass, wr, issue, is_last;
  always_comb begin
    push = rd_en_d && !drop && !frame_start_in;
    pop_req = pix_req_in && !frame_start_in;
    pop = pop_req && count != '0;
    bypass = pop_req && count == '0 && push;
    wr = push && !bypass;
    count_nxt = count + CW'(wr) - CW'(pop);
    // words already requested but not yet in the FIFO must be reserved to avoid overflow
    pending = {1'b0, count} + (CW+1)'(rom_rd_en_out) + (CW+1)'(rd_en_d && !drop);
    issue = (state == PREFETCH || state == STREAM) && !frame_start_in && !last_done
            && pending < (CW+1)'(FIFO_DEPTH);
    is_last = addr == ADDR_W'(LAST);
    state_nxt = frame_start_in ? PREFETCH :
                (state == PREFETCH && count_nxt == CW'(FIFO_DEPTH)) ? STREAM :
                (state == STREAM && issue && is_last) ? DONE : state;
  end
  always_ff @(posedge clk) if (wr) mem[wr_ptr] <= rom_dat_in;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rom_rd_en_out <= 1'b0;
      rom_addr_out <= '0;
      addr <= '0;
      last_done <= 1'b0;
      rd_en_d <= 1'b0;
      drop <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      pix_dat_out <= '0;
      pix_vld_out <= 1'b0;
      ready_out <= 1'b0;
      underrun_out <= 1'b0;
    end else begin
      state <= state_nxt;
      rom_rd_en_out <= issue;
      rd_en_d <= rom_rd_en_out;
      drop <= frame_start_in && rom_rd_en_out;
      pix_vld_out <= pop || bypass;
      pix_dat_out <= pop ? mem[rd_ptr] : bypass ? rom_dat_in : '0;
      if (issue) rom_addr_out <= addr;
      if (frame_start_in) begin
        addr <= '0;
        last_done <= 1'b0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        ready_out <= 1'b0;
        underrun_out <= 1'b0;
      end else begin
        if (issue) begin
          addr <= is_last ? addr : addr + ADDR_W'(1);
          last_done <= is_last;
        end
        if (wr) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count_nxt;
        ready_out <= ready_out || (state == PREFETCH && state_nxt == STREAM);
        underrun_out <= underrun_out || (pop_req && count == '0 && !push);
      end
    end
  end
endmodule

// File: tb/tb_vga_pixel_fetch_ctrl.sv
// tb_vga_pixel_fetch_ctrl: vector table with pixel scoreboard plus async-reset sequence
module tb_vga_pixel_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fs = 1'b0;
  logic req = 1'b0;
  logic rom_rd_en;
  logic [2:0] rom_addr;
  logic [7:0] rom_dat = 8'h00;
  logic [7:0] pix_dat;
  logic pix_vld, ready, underrun;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic fs, req, rd_en;
    logic [2:0] addr;
    logic ready, und, vld;
    logic [7:0] dat;
  } vec_t;
  typedef struct {
    logic vld;
    logic [7:0] dat;
  } pix_t;
  vec_t tv[$];
  pix_t sb[$];
  always #5 clk = ~clk;
  always_ff @(posedge clk) if (rom_rd_en) rom_dat <= 8'h10 + {5'd0, rom_addr};
  vga_pixel_fetch_ctrl #(.DATA_W(8), .H_PIX(4), .V_LINES(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .frame_start_in(fs), .pix_req_in(req),
    .rom_rd_en_out(rom_rd_en), .rom_addr_out(rom_addr), .rom_dat_in(rom_dat),
    .pix_dat_out(pix_dat), .pix_vld_out(pix_vld), .ready_out(ready), .underrun_out(underrun)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic f, r, rd, input logic [2:0] a, input logic rdy, u, v, input logic [7:0] d);
    tv.push_back('{f, r, rd, a, rdy, u, v, d});
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, " rd_en"}, 32'(rom_rd_en), 0);
    chk({tag, " vld"}, 32'(pix_vld), 0);
    chk({tag, " dat"}, 32'(pix_dat), 0);
    chk({tag, " ready"}, 32'(ready), 0);
    chk({tag, " und"}, 32'(underrun), 0);
  endtask
  initial begin
    pix_t p;
    //   fs req rd addr rdy und vld dat
    add(1, 0, 0, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 1, 0, 0, 0, 8'h00);
    add(0, 0, 1, 2, 0, 0, 0, 8'h00);
    add(0, 0, 1, 3, 0, 0, 0, 8'h00);
    add(0, 0, 0, 3, 0, 0, 0, 8'h00);
    add(0, 0, 0, 3, 1, 0, 0, 8'h00);
    add(0, 1, 0, 3, 1, 0, 1, 8'h10);
    add(0, 1, 1, 4, 1, 0, 1, 8'h11);
    add(0, 1, 1, 5, 1, 0, 1, 8'h12);
    add(0, 1, 1, 6, 1, 0, 1, 8'h13);
    add(0, 1, 1, 7, 1, 0, 1, 8'h14);
    add(0, 1, 0, 7, 1, 0, 1, 8'h15);
    add(0, 1, 0, 7, 1, 0, 1, 8'h16);
    add(0, 1, 0, 7, 1, 0, 1, 8'h17);
    add(0, 1, 0, 7, 1, 1, 0, 8'h00);
    add(0, 0, 0, 7, 1, 1, 0, 8'h00);
    add(0, 0, 0, 7, 1, 1, 0, 8'h00);
    add(1, 0, 0, 7, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 1, 0, 0, 0, 8'h00);
    add(0, 0, 1, 2, 0, 0, 0, 8'h00);
    add(1, 0, 0, 2, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 1, 0, 0, 0, 8'h00);
    add(0, 1, 1, 2, 0, 0, 1, 8'h10);
    add(0, 0, 1, 3, 0, 0, 0, 8'h00);
    add(0, 0, 1, 4, 0, 0, 0, 8'h00);
    add(0, 0, 0, 4, 0, 0, 0, 8'h00);
    add(0, 0, 0, 4, 1, 0, 0, 8'h00);
    add(0, 1, 0, 4, 1, 0, 1, 8'h11);
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset addr", 32'(rom_addr), 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      fs = tv[i].fs;
      req = tv[i].req;
      sb.push_back('{tv[i].vld, tv[i].dat});
      @(posedge clk);
      #1;
      p = sb.pop_front();
      chk($sformatf("r%0d vld", i), 32'(pix_vld), 32'(p.vld));
      chk($sformatf("r%0d dat", i), 32'(pix_dat), 32'(p.dat));
      chk($sformatf("r%0d rd_en", i), 32'(rom_rd_en), 32'(tv[i].rd_en));
      chk($sformatf("r%0d addr", i), 32'(rom_addr), 32'(tv[i].addr));
      chk($sformatf("r%0d ready", i), 32'(ready), 32'(tv[i].ready));
      chk($sformatf("r%0d und", i), 32'(underrun), 32'(tv[i].und));
    end
    @(negedge clk);
    fs = 1'b0;
    req = 1'b1;
    @(posedge clk);
    #1;
    chk("pre-rst rd_en", 32'(rom_rd_en), 1);
    chk("pre-rst addr", 32'(rom_addr), 5);
    chk("pre-rst dat", 32'(pix_dat), 32'h12);
    #3 rst = 1'b1;
    #1;
    chk_idle("async rst");
    chk("async rst addr", 32'(rom_addr), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_idle($sformatf("post-rst%0d", i));
    end
    @(negedge clk) fs = 1'b1;
    @(posedge clk);
    #1;
    chk("restart fs rd_en", 32'(rom_rd_en), 0);
    @(negedge clk) fs = 1'b0;
    @(posedge clk);
    #1;
    chk("restart rd_en", 32'(rom_rd_en), 1);
    chk("restart addr", 32'(rom_addr), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
